// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg
//   Shared definitions for the APB master bridge: the FSM state encoding and
//   width helpers for the slave-index field and the access timeout counter.
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Slave-index field width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) == 0) ? 1 : clog2(n);
    endfunction

    // Timeout counter width: at least 8 bits, wide enough for the limit.
    function automatic int unsigned timeout_cnt_width(input int unsigned t);
        return (clog2(t + 1) > 8) ? clog2(t + 1) : 8;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
//   APB bus bundle between the bridge (master) and NUM_SLAVES peripherals.
//   PADDR/PWRITE/PWDATA/PENABLE : shared request signals
//   PSEL                        : one-hot slave select
//   PRDATA                      : concatenated slave read buses, slave i at [i*DATA_W +: DATA_W]
//   PREADY/PSLVERR              : per-slave ready and error
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SLAVES = 4
) ();
    logic [ADDR_W-1:0]            PADDR;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [DATA_W-1:0]            PWDATA;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge_decoder.sv
// apb_slave_decoder
//   Combinational address decode for the APB bridge.
//   addr  : core address; only the field [SEL_LSB +: idx width] is decoded
//   sel   : one-hot slave select, all zero when the index is out of range
//   idx   : raw slave index field
//   valid : index names an existing slave (idx < NUM_SLAVES)
module apb_slave_decoder
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned SEL_LSB    = 12
) (
    input  logic [ADDR_W-1:0]                  addr,
    output logic [NUM_SLAVES-1:0]              sel,
    output logic [idx_width(NUM_SLAVES)-1:0]   idx,
    output logic                               valid
);
    localparam int unsigned IDX_W = idx_width(NUM_SLAVES);
    localparam logic [IDX_W:0] NS = (IDX_W + 1)'(NUM_SLAVES);

    // Address bits outside the index field play no part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    always_comb begin
        idx   = addr[SEL_LSB +: IDX_W];
        valid = ({1'b0, idx} < NS);
        sel   = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = valid && (idx == IDX_W'(i));
        end
    end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Turns one processor-core peripheral request into one APB SETUP->ACCESS
//   transfer, selecting one of NUM_SLAVES slaves from the address. proc_ack
//   is high only while the core may clock (IDLE); the core gates its clock
//   with it, so every accepted request stalls the core until the transfer
//   has finished.
//   Ports:
//     clk, rst       : clock, asynchronous active-low reset
//     proc_transfer  : core request (level, held while stalled)
//     proc_addr/proc_write/proc_wdata : request address, direction, write data
//     proc_rdata     : read data of the last read
//     proc_ack       : 1 = core may clock, 0 = stall
//     proc_err       : last transfer failed (PSLVERR, decode miss or timeout)
//     apb            : APB master modport (PADDR, PSEL, PENABLE, PWRITE,
//                      PWDATA, PRDATA, PREADY, PSLVERR)
//   Build option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
//   cycles without PREADY; otherwise ACCESS waits indefinitely.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_transfer,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic              proc_write,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              proc_ack,
    output logic              proc_err,
    apb_master_bridge_if.master apb
);
    localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

    state_t                state;
    logic [IDX_W-1:0]      idx_q;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_valid;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    apb_slave_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_decoder (
        .addr  (proc_addr),
        .sel   (dec_sel),
        .idx   (dec_idx),
        .valid (dec_valid)
    );

    // proc_ack is registered, so it drops on the accepting edge and rises
    // on the DONE->IDLE edge: the core sees exactly one clock edge (at the
    // end of the IDLE cycle) per transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx_q       <= '0;
            proc_ack    <= 1'b1;
            proc_err    <= 1'b0;
            proc_rdata  <= '0;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWRITE  <= 1'b0;
            apb.PWDATA  <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (proc_transfer) begin
                        apb.PADDR  <= proc_addr;
                        apb.PWRITE <= proc_write;
                        apb.PWDATA <= proc_wdata;
                        idx_q      <= dec_idx;
                        proc_ack   <= 1'b0;
                        if (dec_valid) begin
                            // PSEL is registered here so it is already high in SETUP.
                            apb.PSEL <= dec_sel;
                            proc_err <= 1'b0;
                            state    <= SETUP;
                        end else begin
                            proc_err   <= 1'b1;
                            proc_rdata <= '0;
                            state      <= DONE;
                        end
                    end
                end

                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt     <= '0;
`endif
                end

                ACCESS: begin
                    if (apb.PREADY[idx_q]) begin
                        if (!apb.PWRITE) begin
                            proc_rdata <= apb.PRDATA[int'(idx_q)*DATA_W +: DATA_W];
                        end
                        proc_err    <= apb.PSLVERR[idx_q];
                        apb.PSEL    <= '0;
                        apb.PENABLE <= 1'b0;
                        state       <= DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    // PREADY on the final counted cycle takes the branch above.
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        proc_err    <= 1'b1;
                        proc_rdata  <= '0;
                        apb.PSEL    <= '0;
                        apb.PENABLE <= 1'b0;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                DONE: begin
                    proc_ack <= 1'b1;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge with three slaves (a slave index of
//   3 is a decode miss) and TIMEOUT_CYCLES = 8. A small slave responder
//   supplies fixed read data, a programmable number of wait states for the
//   selected slave, and an error mask.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        proc_transfer;
    logic [31:0] proc_addr;
    logic        proc_write;
    logic [31:0] proc_wdata;
    logic [31:0] proc_rdata;
    logic        proc_ack;
    logic        proc_err;

    int checks   = 0;
    int failures = 0;

    logic        hold_ready;
    logic [7:0]  wait_states;
    logic [7:0]  wcnt;
    logic [2:0]  err_mask;
    logic [31:0] rd0, rd1, rd2;

    int          ack_low;
    logic [2:0]  psel_or;
    int          acc_cyc;
    bit          stable;
    logic        err_acc;

    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) apb ();

    apb_master_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .NUM_SLAVES     (3),
        .SEL_LSB        (12),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .proc_transfer (proc_transfer),
        .proc_addr     (proc_addr),
        .proc_write    (proc_write),
        .proc_wdata    (proc_wdata),
        .proc_rdata    (proc_rdata),
        .proc_ack      (proc_ack),
        .proc_err      (proc_err),
        .apb           (apb.master)
    );

    // Slave responder: wcnt counts completed ACCESS cycles; the selected
    // slave is ready once wcnt reaches wait_states. Unselected slaves always
    // report ready so that any use of their PREADY shows up as early finish.
    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 8'd0;
        else if (apb.PSEL != 3'b000 && apb.PENABLE) wcnt <= wcnt + 8'd1;
        else wcnt <= 8'd0;
    end

    assign apb.PREADY  = ~apb.PSEL | ((!hold_ready && wcnt >= wait_states) ? 3'b111 : 3'b000);
    assign apb.PRDATA  = {rd2, rd1, rd0};
    assign apb.PSLVERR = err_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it until proc_ack returns, at most maxc
    // cycles. Reports stall length, OR of PSEL seen, ACCESS cycle count,
    // request-signal stability while selected, and proc_err just after accept.
    task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input int maxc);
        proc_addr     = a;
        proc_write    = w;
        proc_wdata    = d;
        proc_transfer = 1'b1;
        ack_low = 0;
        psel_or = 3'b000;
        acc_cyc = 0;
        stable  = 1'b1;
        tick();
        err_acc = proc_err;
        while (proc_ack === 1'b0 && ack_low < maxc) begin
            ack_low++;
            psel_or = psel_or | apb.PSEL;
            if (apb.PENABLE === 1'b1) acc_cyc++;
            if (apb.PSEL != 3'b000 &&
                (apb.PADDR !== a || apb.PWRITE !== w || apb.PWDATA !== d)) stable = 1'b0;
            tick();
        end
        proc_transfer = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        proc_transfer = 1'b0;
        proc_addr     = '0;
        proc_write    = 1'b0;
        proc_wdata    = '0;
        hold_ready    = 1'b0;
        wait_states   = 8'd0;
        err_mask      = 3'b000;
        rd0 = 32'h0BAD_0000;
        rd1 = 32'hCAFE_0001;
        rd2 = 32'h2222_0002;

        // Reset state
        tick();
        tick();
        check("rst_ack",     {31'd0, proc_ack},    32'd1);
        check("rst_err",     {31'd0, proc_err},    32'd0);
        check("rst_rdata",   proc_rdata,           32'd0);
        check("rst_psel",    {29'd0, apb.PSEL},    32'd0);
        check("rst_penable", {31'd0, apb.PENABLE}, 32'd0);
        check("rst_paddr",   apb.PADDR,            32'd0);
        check("rst_pwrite",  {31'd0, apb.PWRITE},  32'd0);
        check("rst_pwdata",  apb.PWDATA,           32'd0);
        rst = 1'b1;
        tick();

        // 1: read slave 1, no wait states
        run_xfer(32'h0000_1004, 1'b0, 32'h0, 20);
        check("t1_ack_low", ack_low,             32'd3);
        check("t1_psel",    {29'd0, psel_or},    32'h2);
        check("t1_access",  acc_cyc,             32'd1);
        check("t1_rdata",   proc_rdata,          32'hCAFE_0001);
        check("t1_err",     {31'd0, proc_err},   32'd0);

        // 2: write slave 2, three wait states
        wait_states = 8'd3;
        run_xfer(32'h0000_2010, 1'b1, 32'h1234_5678, 20);
        wait_states = 8'd0;
        check("t2_ack_low", ack_low,             32'd6);
        check("t2_psel",    {29'd0, psel_or},    32'h4);
        check("t2_access",  acc_cyc,             32'd4);
        check("t2_stable",  {31'd0, stable},     32'd1);
        check("t2_rdata",   proc_rdata,          32'hCAFE_0001);
        check("t2_err",     {31'd0, proc_err},   32'd0);

        // 3: slave error on slave 0, then a clean read clears it
        err_mask = 3'b001;
        run_xfer(32'h0000_0008, 1'b0, 32'h0, 20);
        err_mask = 3'b000;
        check("t3_ack_low", ack_low,             32'd3);
        check("t3_psel",    {29'd0, psel_or},    32'h1);
        check("t3_err",     {31'd0, proc_err},   32'd1);
        check("t3_rdata",   proc_rdata,          32'h0BAD_0000);
        run_xfer(32'h0000_2000, 1'b0, 32'h0, 20);
        check("t3_err_cleared_on_accept", {31'd0, err_acc}, 32'd0);
        check("t3_err_clean", {31'd0, proc_err}, 32'd0);
        check("t3_rdata2",  proc_rdata,          32'h2222_0002);

        // Upper address bits are ignored for decode
        run_xfer(32'hF000_5004, 1'b0, 32'h0, 20);
        check("hi_psel",    {29'd0, psel_or},    32'h2);
        check("hi_rdata",   proc_rdata,          32'hCAFE_0001);

        // 4: decode miss (index 3 with three slaves)
        run_xfer(32'h0000_3000, 1'b0, 32'h0, 20);
        check("t4_ack_low", ack_low,             32'd1);
        check("t4_psel",    {29'd0, psel_or},    32'h0);
        check("t4_err",     {31'd0, proc_err},   32'd1);
        check("t4_rdata",   proc_rdata,          32'h0);
        check("t4_paddr",   apb.PADDR,           32'h0000_3000);

        // 5: asynchronous reset during ACCESS
        hold_ready    = 1'b1;
        proc_addr     = 32'h0000_0000;
        proc_write    = 1'b0;
        proc_transfer = 1'b1;
        tick();
        check("t5_setup_psel",    {29'd0, apb.PSEL},    32'h1);
        check("t5_setup_penable", {31'd0, apb.PENABLE}, 32'd0);
        tick();
        proc_transfer = 1'b0;
        check("t5_access_penable", {31'd0, apb.PENABLE}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_psel",    {29'd0, apb.PSEL},    32'h0);
        check("t5_rst_penable", {31'd0, apb.PENABLE}, 32'd0);
        check("t5_rst_ack",     {31'd0, proc_ack},    32'd1);
        tick();
        rst        = 1'b1;
        hold_ready = 1'b0;
        tick();
        run_xfer(32'h0000_0000, 1'b0, 32'h0, 20);
        check("t5_after_ack_low", ack_low,           32'd3);
        check("t5_after_psel",    {29'd0, psel_or},  32'h1);
        check("t5_after_access",  acc_cyc,           32'd1);
        check("t5_after_rdata",   proc_rdata,        32'h0BAD_0000);

`ifdef APB_TIMEOUT_EN
        // 6: timeout after 8 ACCESS cycles
        hold_ready = 1'b1;
        run_xfer(32'h0000_1000, 1'b0, 32'h0, 30);
        hold_ready = 1'b0;
        check("t6_ack_low", ack_low,             32'd10);
        check("t6_access",  acc_cyc,             32'd8);
        check("t6_err",     {31'd0, proc_err},   32'd1);
        check("t6_rdata",   proc_rdata,          32'h0);
        // PREADY on the 8th ACCESS cycle completes normally
        wait_states = 8'd7;
        run_xfer(32'h0000_1000, 1'b0, 32'h0, 30);
        wait_states = 8'd0;
        check("t6_edge_access", acc_cyc,           32'd8);
        check("t6_edge_err",    {31'd0, proc_err}, 32'd0);
        check("t6_edge_rdata",  proc_rdata,        32'hCAFE_0001);
`else
        // 6: without the timeout, ACCESS waits indefinitely
        hold_ready    = 1'b1;
        proc_addr     = 32'h0000_1000;
        proc_write    = 1'b0;
        proc_transfer = 1'b1;
        tick();
        proc_transfer = 1'b0;
        repeat (1000) tick();
        check("t6_still_psel",    {29'd0, apb.PSEL},    32'h2);
        check("t6_still_penable", {31'd0, apb.PENABLE}, 32'd1);
        check("t6_still_ack",     {31'd0, proc_ack},    32'd0);
        hold_ready = 1'b0;
        ack_low = 0;
        while (proc_ack === 1'b0 && ack_low < 10) begin
            ack_low++;
            tick();
        end
        check("t6_release_ack",   {31'd0, proc_ack},    32'd1);
        check("t6_release_rdata", proc_rdata,           32'hCAFE_0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
